// File: rtl/trafficgen_regs_pkg.sv
// Shared constants and types for the trafficgen AXI4-Lite register slave.
// Register indices, response codes and the write-path state encoding.
package trafficgen_regs_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] REG0 = 2'd0;
  localparam logic [1:0] REG1 = 2'd1;
  localparam logic [1:0] REG2 = 2'd2;
  localparam logic [1:0] REG3 = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

endpackage

// File: rtl/trafficgen_axil_wr_ctrl.sv
// AXI4-Lite write channel controller: AW/W holding registers,
// commit strobe towards the register file and B response.
module trafficgen_axil_wr_ctrl
  import trafficgen_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [1:0]  awidx,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        wr_en,
  output logic [1:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb
);

  wr_state_e   state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic        aw_hs;
  logic        w_hs;

  // Ready stays low until the first edge after reset is released.
  assign awready = rdy_q &
                   ((state_q == WR_IDLE) |
                    (state_q == WR_HAVE_W));
  assign wready  = rdy_q &
                   ((state_q == WR_IDLE) |
                    (state_q == WR_HAVE_AW));
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  assign bvalid  = (state_q == WR_RESP);
  assign bresp   = RESP_OKAY;
  assign wr_en   = (state_q == WR_COMMIT);
  assign wr_idx  = idx_q;
  assign wr_data = data_q;
  assign wr_strb = strb_q;

  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    strb_d  = strb_q;
    if (aw_hs) idx_d = awidx;
    if (w_hs) begin
      data_d = wdata;
      strb_d = wstrb;
    end
    unique case (state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) state_d = WR_COMMIT;
        else if (aw_hs)    state_d = WR_HAVE_AW;
        else if (w_hs)     state_d = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)   state_d = WR_COMMIT;
      WR_HAVE_W:  if (aw_hs)  state_d = WR_COMMIT;
      WR_COMMIT:              state_d = WR_RESP;
      WR_RESP:    if (bready) state_d = WR_IDLE;
      default:                state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WR_IDLE;
      rdy_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

endmodule

// File: rtl/trafficgen_s_axi_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers.
// Write FSM lives in trafficgen_axil_wr_ctrl; reads are served here.
module trafficgen_s_axi_regs
  import trafficgen_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic        rd_rdy_q;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ar_hs;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR, S_AXI_ARADDR};

  trafficgen_axil_wr_ctrl u_wr_ctrl (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .awidx   (S_AXI_AWADDR[3:2]),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  assign S_AXI_ARREADY = rd_rdy_q & ~rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b])
          regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // A read sampling regs_q sees the value before a same-edge commit.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      rd_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      rd_rdy_q <= 1'b1;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_trafficgen_s_axi_regs.sv
// Self-checking bench for trafficgen_s_axi_regs: directed scenarios
// plus random traffic against a byte-mask register model.
module tb_trafficgen_s_axi_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int errs   = 0;
  int checks = 0;
  longint t_aw, t_w;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  trafficgen_s_axi_regs dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void model_wr(input logic [3:0] a,
                                   input logic [31:0] d,
                                   input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model[a[3:2]] = (model[a[3:2]] & ~m) | (d & m);
  endfunction

  // lead > 0: W goes that many cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int lead,
                           input int bdly);
    int aw_dly;
    int w_dly;
    int n;
    aw_dly = (lead > 0) ? lead : 0;
    w_dly  = (lead < 0) ? -lead : 0;
    bready = (bdly == 0);
    fork
      begin
        int k = 0;
        repeat (aw_dly) @(posedge clk);
        if (aw_dly > 0) #1;
        awaddr  = a;
        awprot  = 3'($urandom);
        awvalid = 1'b1;
        do begin @(negedge clk); k++; end
        while (!awready && k < 50);
        if (!awready) chk("aw_timeout", 0, 1);
        @(posedge clk);
        t_aw = $time;
        #1 awvalid = 1'b0;
      end
      begin
        int k = 0;
        repeat (w_dly) @(posedge clk);
        if (w_dly > 0) #1;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        do begin @(negedge clk); k++; end
        while (!wready && k < 50);
        if (!wready) chk("w_timeout", 0, 1);
        @(posedge clk);
        t_w = $time;
        #1 wvalid = 1'b0;
      end
    join
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", 32'(bvalid), 1);
    chk("bresp", 32'(bresp), 0);
    for (int i = 0; i < bdly; i++) begin
      chk("bvalid_hold", 32'(bvalid), 1);
      chk("awrdy_bp", 32'(awready), 0);
      chk("wrdy_bp", 32'(wready), 0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    chk("bvalid_clr", 32'(bvalid), 0);
    model_wr(a, d, s);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp,
                          input int rdly, input string tag);
    int k = 0;
    rready  = (rdly == 0);
    araddr  = a;
    arprot  = 3'($urandom);
    arvalid = 1'b1;
    do begin @(negedge clk); k++; end
    while (!arready && k < 50);
    if (!arready) chk("ar_timeout", 0, 1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 1);
    chk(tag, rdata, exp);
    chk("rresp", 32'(rresp), 0);
    repeat (rdly) begin
      @(posedge clk);
      #1;
      chk("rdata_hold", rdata, exp);
      chk("rvalid_hold", 32'(rvalid), 1);
    end
    rready = 1'b1;
    @(posedge clk);
    #1;
    chk("rvalid_clr", 32'(rvalid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ra;
    logic [31:0] rd;
    rst_n   = 1'b0;
    awaddr  = '0; awprot = '0; awvalid = 1'b0;
    wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
    araddr  = '0; arprot = '0; arvalid = 1'b0;
    bready  = 1'b1;
    rready  = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awrdy", 32'(awready), 0);
    chk("rst_wrdy", 32'(wready), 0);
    chk("rst_arrdy", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", 32'(bresp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_awrdy_low", 32'(awready), 0);
    @(posedge clk);
    #1;
    chk("rel_awrdy", 32'(awready), 1);
    chk("rel_wrdy", 32'(wready), 1);
    chk("rel_arrdy", 32'(arready), 1);

    for (int i = 0; i < 4; i++)
      axi_read(4'(i * 4), 0, 0, "rst_reg");

    for (int i = 0; i < 4; i++)
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++)
      axi_read(4'(i * 4), 32'(i + 1), 0, "seq_rd");

    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0);
    chk("w_before_aw", 32'(t_w < t_aw), 1);
    axi_read(4'h8, 32'hDEADBEEF, 0, "wfirst_rd");

    axi_write(4'h4, 32'h11223344, 4'hF, -2, 0);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0);
    axi_read(4'h4, 32'h11BB33DD, 0, "strb_rd");

    axi_write(4'hC, 32'hFFFFFFFF, 4'b0000, 1, 0);
    axi_read(4'hC, 32'h4, 0, "strb0_rd");

    axi_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 10);
    axi_read(4'h0, 32'hCAFEF00D, 10, "bp_rd");

    axi_write(4'h8, 32'h5, 4'hF, 0, 0);
    @(posedge clk);
    #1;
    chk("col_awrdy", 32'(awready), 1);
    awaddr = 4'h8; wdata = 32'h9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("col_bvalid_early", 32'(bvalid), 0);
    chk("col_arrdy", 32'(arready), 1);
    araddr = 4'h8; arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    chk("col_rdata", rdata, 32'h5);
    chk("col_rvalid", 32'(rvalid), 1);
    chk("col_bvalid", 32'(bvalid), 1);
    @(posedge clk);
    #1;
    chk("col_bvalid_clr", 32'(bvalid), 0);
    chk("col_rvalid_clr", 32'(rvalid), 0);
    model_wr(4'h8, 32'h9, 4'hF);
    axi_read(4'h8, 32'h9, 0, "col_after");

    for (int i = 0; i < 60; i++) begin
      ra = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rd = $urandom;
        axi_write(ra, rd, 4'($urandom),
                  int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 2)));
      end else begin
        axi_read(ra, model[ra[3:2]],
                 int'($urandom_range(0, 2)), "rnd_rd");
      end
    end
    for (int i = 0; i < 4; i++)
      axi_read(4'(i * 4), model[i], 0, "rnd_final");

    @(posedge clk);
    #1;
    awaddr = 4'h4; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    begin
      int k = 0;
      while (!bvalid && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    chk("mid_bvalid", 32'(bvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    chk("mid_rst_awrdy", 32'(awready), 0);
    chk("mid_rst_arrdy", 32'(arready), 0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    bready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_awrdy", 32'(awready), 1);
    for (int i = 0; i < 4; i++)
      axi_read(4'(i * 4), model[i], 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
